instruction_cache: RTL and testbench

- Read-only, direct-mapped instruction cache on the fetch side of the pipeline.
- Acts as the instruction-side requester of memory_controller: drives reqI_cache/reqAddrI_mem and consumes data_to_cache/read_ready_for_icache.
- Counterpart to data_cache on the instruction channel, which is left unconnected in the cache test top.
- Serves 32-bit instructions from 128-bit lines; stalls fetch while a line fill is outstanding.

---
 rtl/instruction_cache.sv | 183 ++++++++++++++++++
 tb/tb_instruction_cache.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// instruction_cache: read-only, direct-mapped instruction cache on the fetch side.
// Serves 32-bit words from 128-bit lines. A hit answers combinationally in the
// same cycle. A miss stalls fetch and issues one line read to the memory
// controller, then waits for the fill pulse.
//
// Optional build macro: ICACHE_STATS_EN adds the hit_count/miss_count outputs.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                invalidate all lines at the clock edge
//   fetch_req, pc        fetch request and byte address (pc[1:0], pc[31:30] ignored)
//   instr, instr_valid   fetched word and its valid flag (combinational)
//   reqI_stop            fetch stall while a miss is outstanding (combinational)
//   reqI_mem             line read request to memory (registered)
//   reqAddrI_mem         line address pc[29:4] (registered)
//   data_from_mem        128-bit fill line
//   read_ready_from_mem  one-cycle fill valid pulse
//   hit_count, miss_count  (ICACHE_STATS_EN only) lookup counters
module instruction_cache #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 fetch_req,
    input  logic [31:0]          pc,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 reqI_stop,
    output logic                 reqI_mem,
    output logic [25:0]          reqAddrI_mem,
    input  logic [LINE_BITS-1:0] data_from_mem,
    input  logic                 read_ready_from_mem
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
    localparam int unsigned LADDR_BITS = 26;
    localparam int unsigned TAG_BITS   = LADDR_BITS - INDEX_BITS;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [LADDR_BITS-1:0]   addr_q, addr_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]    data_q [NUM_LINES];
    logic                    fill_we;
    logic                    hit_inc;
    logic                    miss_inc;

    // Address decode of the presented pc
    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_BITS-1:0]     pc_tag;
    logic [1:0]              pc_word;
    logic                    pc_hit;
    logic [LINE_BITS-1:0]    rd_line;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    unused_pc_bits;

    assign pc_word        = pc[3:2];
    assign pc_index       = pc[4 +: INDEX_BITS];
    assign pc_tag         = pc[4 + INDEX_BITS +: TAG_BITS];
    assign pc_hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign rd_line        = data_q[pc_index];
    assign fill_index     = addr_q[INDEX_BITS-1:0];
    assign fill_tag       = addr_q[INDEX_BITS +: TAG_BITS];
    assign unused_pc_bits = ^{pc[31:30], pc[1:0]};

    // Next-state and fetch-side outputs
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        fill_we     = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        reqI_stop   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    if (pc_hit) begin
                        instr       = rd_line[{pc_word, 5'b00000} +: 32];
                        instr_valid = 1'b1;
                        hit_inc     = 1'b1;
                    end else begin
                        reqI_stop = 1'b1;
                        miss_inc  = 1'b1;
                        req_d     = 1'b1;
                        addr_d    = pc[29:4];
                        state_d   = S_MISS;
                    end
                end
            end
            S_MISS: begin
                reqI_stop = 1'b1;
                if (read_ready_from_mem) begin
                    // A coincident flush suppresses the fill entirely
                    fill_we = !flush;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush is applied after the fill so it always wins
        valid_d = valid_q;
        if (fill_we) valid_d[fill_index] = 1'b1;
        if (flush)   valid_d = '0;

        if (reset) begin
            instr       = '0;
            instr_valid = 1'b0;
            reqI_stop   = 1'b0;
            fill_we     = 1'b0;
            hit_inc     = 1'b0;
            miss_inc    = 1'b0;
        end
    end

    // Control state and valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= data_from_mem;
        end
    end

    assign reqI_mem     = req_q;
    assign reqAddrI_mem = addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Lookup counters; flush leaves them alone, they wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Testbench for instruction_cache: directed sequences, a vector table of hits,
// and randomized traffic against a line-level reference model.
module tb_instruction_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         fetch_req;
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         reqI_stop;
    logic         reqI_mem;
    logic [25:0]  reqAddrI_mem;
    logic [127:0] data_from_mem;
    logic         read_ready_from_mem;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_cache #(.NUM_LINES(4), .LINE_BITS(128)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .fetch_req           (fetch_req),
        .pc                  (pc),
        .instr               (instr),
        .instr_valid         (instr_valid),
        .reqI_stop           (reqI_stop),
        .reqI_mem            (reqI_mem),
        .reqAddrI_mem        (reqAddrI_mem),
        .data_from_mem       (data_from_mem),
        .read_ready_from_mem (read_ready_from_mem)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count           (hit_count),
        .miss_count          (miss_count)
`endif
    );

    typedef struct {
        logic        fetch;
        logic [31:0] addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [31:0] p, input logic rdy,
                         input logic [127:0] d, input logic fl);
        fetch_req           = f;
        pc                  = p;
        read_ready_from_mem = rdy;
        data_from_mem       = d;
        flush               = fl;
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    // Complete miss + fill for the line holding p, then confirm the word hits
    task automatic fill(input string nm, input logic [31:0] p, input logic [127:0] d);
        logic [31:0] w;
        drive(1'b1, p, 1'b0, '0, 1'b0);
        #3;
        chk({nm, " miss stop"}, reqI_stop, 1'b1);
        chk({nm, " miss valid"}, instr_valid, 1'b0);
        tick();
        chk({nm, " req"}, reqI_mem, 1'b1);
        chk({nm, " req addr"}, reqAddrI_mem, p[29:4]);
        drive(1'b0, 32'h0, 1'b1, d, 1'b0);
        tick();
        chk({nm, " req drop"}, reqI_mem, 1'b0);
        drive(1'b1, p, 1'b0, '0, 1'b0);
        #3;
        w = d[{p[3:2], 5'b00000} +: 32];
        chk({nm, " refetch valid"}, instr_valid, 1'b1);
        chk({nm, " refetch instr"}, instr, w);
        tick();
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
    endtask

    // Reference model state: one entry per line, plus the outstanding request
    bit          m_valid [4];
    int unsigned m_tag   [4];
    logic [127:0] m_line [4];
    bit          m_pend;
    logic [25:0] m_paddr;
    int unsigned m_hits, m_misses;

    vec_t vecs [11];

    initial begin
        logic [127:0] tp_line;
        logic [127:0] rnd_d;

        drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        #3;
        chk("rst reqI_mem", reqI_mem, 1'b0);
        chk("rst reqAddr", reqAddrI_mem, 26'h0);
        chk("rst instr_valid", instr_valid, 1'b0);
        chk("rst reqI_stop", reqI_stop, 1'b0);
        chk("rst instr", instr, 32'h0);
        tick();

        // First miss and fill
        tp_line = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        fill("pc10", 32'h0000_0014, tp_line);
        drive(1'b1, 32'h0000_001C, 1'b0, '0, 1'b0);
        #3;
        chk("pc1c instr", instr, 32'h44443333);
        chk("pc1c stop", reqI_stop, 1'b0);
        tick();
        chk("pc1c no req", reqI_mem, 1'b0);

        fill("line00", 32'h0000_0000, mk_line(32'hA000_0000));
        fill("line20", 32'h0000_0020, mk_line(32'hA000_0020));
        fill("line30", 32'h0000_0030, mk_line(32'hA000_0030));

        vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'hA000_0000};
        vecs[1]  = '{1'b1, 32'h0000_0004, 1'b1, 32'hA000_0001};
        vecs[2]  = '{1'b1, 32'h0000_000C, 1'b1, 32'hA000_0003};
        vecs[3]  = '{1'b1, 32'h0000_0028, 1'b1, 32'hA000_0022};
        vecs[4]  = '{1'b1, 32'h0000_0034, 1'b1, 32'hA000_0031};
        vecs[5]  = '{1'b1, 32'h0000_0010, 1'b1, 32'hBBBBAAAA};
        vecs[6]  = '{1'b1, 32'h0000_0018, 1'b1, 32'h22221111};
        vecs[7]  = '{1'b0, 32'h0000_0004, 1'b0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 32'hC000_0024, 1'b1, 32'hA000_0021};
        vecs[9]  = '{1'b1, 32'h0000_0003, 1'b1, 32'hA000_0000};
        vecs[10] = '{1'b1, 32'h0000_003F, 1'b1, 32'hA000_0033};
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].fetch, vecs[i].addr, 1'b0, '0, 1'b0);
            #3;
            chk($sformatf("vec%0d valid", i), instr_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d stop", i), reqI_stop, 1'b0);
            tick();
            chk($sformatf("vec%0d req", i), reqI_mem, 1'b0);
        end

        // Conflict miss replaces line 1, old tag then misses
        fill("pc50", 32'h0000_0050, mk_line(32'hB000_0050));
        fill("pc10 again", 32'h0000_0010, tp_line);

        // Flush: same-cycle lookup still sees the old contents
        drive(1'b1, 32'h0000_0020, 1'b0, '0, 1'b1);
        #3;
        chk("flush cycle hit", instr_valid, 1'b1);
        chk("flush cycle instr", instr, 32'hA000_0020);
        tick();
        fill("post-flush pc20", 32'h0000_0020, mk_line(32'hC000_0020));

        // Long miss with ready held low and pc wandering
        drive(1'b1, 32'h0000_0030, 1'b0, '0, 1'b0);
        #3;
        chk("long miss stop", reqI_stop, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'b0, '0, 1'b0);
            #3;
            chk($sformatf("long%0d stop", i), reqI_stop, 1'b1);
            chk($sformatf("long%0d valid", i), instr_valid, 1'b0);
            tick();
            chk($sformatf("long%0d req", i), reqI_mem, 1'b1);
            chk($sformatf("long%0d addr", i), reqAddrI_mem, 26'h3);
        end
        drive(1'b0, 32'h0, 1'b1, mk_line(32'hD000_0030), 1'b0);
        tick();
        chk("long fill drop", reqI_mem, 1'b0);
        drive(1'b1, 32'h0000_0038, 1'b0, '0, 1'b0);
        #3;
        chk("long refetch", instr, 32'hD000_0032);
        tick();

        // Flush coincident with the fill pulse
        drive(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
        tick();
        chk("fr req", reqI_mem, 1'b1);
        drive(1'b0, 32'h0, 1'b1, mk_line(32'hE000_0040), 1'b1);
        tick();
        chk("fr idle", reqI_mem, 1'b0);
        drive(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
        #3;
        chk("fr remiss stop", reqI_stop, 1'b1);
        chk("fr remiss valid", instr_valid, 1'b0);
        tick();
        chk("fr new req", reqI_mem, 1'b1);
        chk("fr new addr", reqAddrI_mem, 26'h4);

        // Reset while the miss is outstanding, then a stray fill pulse
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst req", reqI_mem, 1'b0);
        drive(1'b0, 32'h0, 1'b1, mk_line(32'hF000_0040), 1'b0);
        tick();
        chk("stray ready req", reqI_mem, 1'b0);
        drive(1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
        #3;
        chk("stray ready no write", instr_valid, 1'b0);
        chk("stray ready stop", reqI_stop, 1'b1);

        // Randomized traffic against the model, starting from reset
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_pend = 1'b0;
        m_paddr = '0;
        m_hits = 0;
        m_misses = 0;
`ifdef ICACHE_STATS_EN
        chk("stats rst hit", hit_count, 32'h0);
        chk("stats rst miss", miss_count, 32'h0);
`endif
        for (int n = 0; n < 800; n++) begin
            logic        f, rdy, fl, hit, ev, es;
            logic [31:0] p, ei;
            int unsigned idx, tg;
            f     = ($urandom % 4) != 0;
            p     = $urandom & 32'hC000_007F;
            rdy   = m_pend ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
            fl    = ($urandom % 20) == 0;
            rnd_d = {$urandom, $urandom, $urandom, $urandom};
            drive(f, p, rdy, rnd_d, fl);
            #3;
            idx = (p >> 4) % 4;
            tg  = (p & 32'h3FFF_FFFF) >> 6;
            hit = 1'b0;
            ev = 1'b0; ei = 32'h0; es = 1'b0;
            if (m_pend) begin
                es = 1'b1;
            end else if (f) begin
                hit = m_valid[idx] && (m_tag[idx] == tg);
                if (hit) begin
                    ev = 1'b1;
                    ei = m_line[idx][(p[3:2] * 32) +: 32];
                    m_hits++;
                end else begin
                    es = 1'b1;
                    m_misses++;
                end
            end
            chk($sformatf("rnd%0d valid", n), instr_valid, ev);
            chk($sformatf("rnd%0d instr", n), instr, ei);
            chk($sformatf("rnd%0d stop", n), reqI_stop, es);
            if (m_pend) begin
                if (rdy) begin
                    if (!fl) begin
                        m_valid[m_paddr % 4] = 1'b1;
                        m_tag[m_paddr % 4]   = m_paddr / 4;
                        m_line[m_paddr % 4]  = rnd_d;
                    end
                    m_pend = 1'b0;
                end
            end else if (f && !hit) begin
                m_pend  = 1'b1;
                m_paddr = p[29:4];
            end
            if (fl) for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
            tick();
            chk($sformatf("rnd%0d req", n), reqI_mem, m_pend);
            chk($sformatf("rnd%0d addr", n), reqAddrI_mem, m_paddr);
        end

`ifdef ICACHE_STATS_EN
        chk("stats hits", hit_count, m_hits);
        chk("stats misses", miss_count, m_misses);
        drive(1'b0, 32'h0, 1'b0, '0, 1'b1);
        tick();
        chk("stats flush hits", hit_count, m_hits);
        chk("stats flush misses", miss_count, m_misses);
        drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stats reset hits", hit_count, 32'h0);
        chk("stats reset misses", miss_count, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
